// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// Bus layout, device IDs, instruction classes and state encodings.
package control_sequencer_pkg;

  localparam int CTRL_BUS_WIDTH = 20;

  localparam int OFS_SID_EN = 0;
  localparam int OFS_MID_EN = 1;
  localparam int OFS_PC_INR = 2;
  localparam int OFS_AMID   = 3;
  localparam int OFS_SID    = 5;
  localparam int OFS_MID    = 10;
  localparam int OFS_ALU_OP = 15;

  localparam int DEF_MEM_ID  = 4;
  localparam int DEF_IR0_ID  = 0;
  localparam int DEF_IR1_ID  = 1;
  localparam int DEF_ALU_ID  = 5;
  localparam int DEF_PC_AMID = 0;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_MOV = 3'd1,
    CLS_ALU = 3'd2,
    CLS_HLT = 3'd7
  } iclass_t;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_HALT = 4'd15
  } state_t;

  // Field order matches the packed control bus, MSB first.
  typedef struct packed {
    logic [4:0] alu_opcode;
    logic [4:0] mid;
    logic [4:0] sid;
    logic [1:0] amid;
    logic       pc_inr;
    logic       mid_en;
    logic       sid_en;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Packed control bus driven by the sequencer, consumed by the datapath.
// Individual fields plus their 20-bit concatenation.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic [4:0] alu_opcode;
  logic [4:0] mid;
  logic [4:0] sid;
  logic [1:0] amid;
  logic       pc_inr;
  logic       mid_en;
  logic       sid_en;
  logic [CTRL_BUS_WIDTH-1:0] control_bus;

  modport master (
    output alu_opcode, mid, sid, amid,
    output pc_inr, mid_en, sid_en,
    output control_bus
  );

  modport slave (
    input alu_opcode, mid, sid, amid,
    input pc_inr, mid_en, sid_en,
    input control_bus
  );

endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational instruction decode from {IR1, IR0} to execute controls.
// self_write flags a transfer whose source and destination IDs coincide.
module control_sequencer_decoder
  import control_sequencer_pkg::*;
#(
  parameter int ALU_ID = DEF_ALU_ID
) (
  input  logic [15:0] ir,
  output state_t      next_state,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  mid,
  output logic [4:0]  sid,
  output logic        self_write
);

  iclass_t cls;
  logic    unused_ir;

  assign cls       = iclass_t'(ir[7:5]);
  assign unused_ir = ^ir[15:13];

  always_comb begin
    next_state = S_T0;
    alu_opcode = '0;
    mid        = '0;
    sid        = '0;
    unique case (1'b1)
      (cls == CLS_MOV): begin
        next_state = S_E0;
        mid        = ir[12:8];
        sid        = ir[4:0];
      end
      (cls == CLS_ALU): begin
        next_state = S_E0;
        alu_opcode = ir[4:0];
        mid        = 5'(ALU_ID);
        sid        = ir[12:8];
      end
      (cls == CLS_HLT): begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_T0;
      end
    endcase
  end

  assign self_write = (mid == sid);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer; state and controls update
// on the falling clock edge so the datapath sees them stable at rise.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_ID  = DEF_MEM_ID,
  parameter int IR0_ID  = DEF_IR0_ID,
  parameter int IR1_ID  = DEF_IR1_ID,
  parameter int ALU_ID  = DEF_ALU_ID,
  parameter int PC_AMID = DEF_PC_AMID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  control_sequencer_if.master cb,
  output logic [3:0]  tstate,
  output logic        halted
);

  state_t     state;
  ctrl_t      ctrl;
  state_t     dec_next;
  logic [4:0] dec_alu;
  logic [4:0] dec_mid;
  logic [4:0] dec_sid;
  logic       dec_self;

  control_sequencer_decoder #(
    .ALU_ID (ALU_ID)
  ) u_dec (
    .ir         (ir),
    .next_state (dec_next),
    .alu_opcode (dec_alu),
    .mid        (dec_mid),
    .sid        (dec_sid),
    .self_write (dec_self)
  );

  function automatic ctrl_t rst_ctrl();
    ctrl_t c;
    c      = '0;
    c.mid  = 5'(MEM_ID);
    c.amid = 2'(PC_AMID);
    return c;
  endfunction

  function automatic ctrl_t t0_ctrl();
    ctrl_t c;
    c        = rst_ctrl();
    c.mid_en = 1'b1;
    return c;
  endfunction

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_T0;
      ctrl   <= rst_ctrl();
      halted <= 1'b0;
    end else begin
      unique case (state)
        S_T0: begin
          state       <= S_T1;
          ctrl.mid    <= 5'(MEM_ID);
          ctrl.amid   <= 2'(PC_AMID);
          ctrl.sid    <= 5'(IR0_ID);
          ctrl.mid_en <= 1'b1;
          ctrl.sid_en <= 1'b1;
          ctrl.pc_inr <= 1'b1;
        end
        S_T1: begin
          state       <= S_T2;
          ctrl.sid_en <= 1'b0;
          ctrl.pc_inr <= 1'b0;
        end
        S_T2: begin
          state       <= S_T3;
          ctrl.sid    <= 5'(IR1_ID);
          ctrl.sid_en <= 1'b1;
          ctrl.pc_inr <= 1'b1;
        end
        S_T3: begin
          state       <= S_T4;
          ctrl.mid_en <= 1'b0;
          ctrl.sid_en <= 1'b0;
          ctrl.pc_inr <= 1'b0;
        end
        S_T4: begin
          unique case (dec_next)
            S_E0: begin
              state <= S_E0;
              ctrl  <= ctrl_t'{
                alu_opcode: dec_alu,
                mid:        dec_mid,
                sid:        dec_sid,
                amid:       2'(PC_AMID),
                pc_inr:     1'b0,
                mid_en:     1'b1,
                sid_en:     !dec_self
              };
            end
            S_HALT: begin
              state       <= S_HALT;
              halted      <= 1'b1;
              ctrl.mid_en <= 1'b0;
              ctrl.sid_en <= 1'b0;
              ctrl.pc_inr <= 1'b0;
            end
            default: begin
              state <= S_T0;
              ctrl  <= t0_ctrl();
            end
          endcase
        end
        S_E0: begin
          state       <= S_E1;
          ctrl.mid_en <= 1'b0;
          ctrl.sid_en <= 1'b0;
        end
        S_E1: begin
          state <= S_T0;
          ctrl  <= t0_ctrl();
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_T0;
          ctrl  <= t0_ctrl();
        end
      endcase
    end
  end

  assign tstate         = state;
  assign cb.alu_opcode  = ctrl.alu_opcode;
  assign cb.mid         = ctrl.mid;
  assign cb.sid         = ctrl.sid;
  assign cb.amid        = ctrl.amid;
  assign cb.pc_inr      = ctrl.pc_inr;
  assign cb.mid_en      = ctrl.mid_en;
  assign cb.sid_en      = ctrl.sid_en;
  assign cb.control_bus = ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for the control sequencer: fetch, MOV, ALU,
// self-move, halt and asynchronous reset behaviour.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic [3:0]  tstate;
  logic        halted;
  int          checks;
  int          errors;
  int          viol;
  int          pulses;
  int          halt_act;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .ir     (ir),
    .cb     (bus),
    .tstate (tstate),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.mid_en && bus.sid_en && bus.mid == bus.sid)
        viol++;
      if (bus.pc_inr && (tstate == 4'd5 || tstate == 4'd6 || tstate == 4'd15))
        viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    viol   = 0;
    reset  = 1'b1;
    ir     = 16'h0000;
    step();
    step();
    chk("rst_tstate", 32'(tstate), 32'd0);
    chk("rst_bus", 32'(bus.control_bus), 32'h01000);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // NOP fetch loop
    step();
    chk("nop_t1", 32'(tstate), 32'd1);
    chk("nop_t1_bus", 32'(bus.control_bus), 32'h01007);
    pulses = int'(bus.pc_inr);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("nop_seq", 32'(tstate), 32'(i));
      pulses += int'(bus.pc_inr);
    end
    chk("nop_t4_bus", 32'(bus.control_bus), 32'h01020);
    step();
    pulses += int'(bus.pc_inr);
    chk("nop_t0", 32'(tstate), 32'd0);
    chk("nop_t0_bus", 32'(bus.control_bus), 32'h01002);
    chk("nop_pulses", 32'(pulses), 32'd2);

    // MOV src 2 -> dst 3
    ir = 16'h0223;
    repeat (5) step();
    chk("mov_e0", 32'(tstate), 32'd5);
    chk("mov_e0_bus", 32'(bus.control_bus), 32'h00863);
    step();
    chk("mov_e1", 32'(tstate), 32'd6);
    chk("mov_e1_bus", 32'(bus.control_bus), 32'h00860);
    step();
    chk("mov_lat", 32'(tstate), 32'd0);

    // ALU op 5, dst 7
    ir = 16'h0745;
    repeat (5) step();
    chk("alu_e0_bus", 32'(bus.control_bus), 32'h294E3);
    step();
    chk("alu_e1_bus", 32'(bus.control_bus), 32'h294E0);
    step();
    chk("alu_lat", 32'(tstate), 32'd0);

    // MOV 3 -> 3: no self write
    ir = 16'h0323;
    repeat (5) step();
    chk("self_e0_bus", 32'(bus.control_bus), 32'h00C62);
    step();
    chk("self_e1_bus", 32'(bus.control_bus), 32'h00C60);
    step();
    chk("self_lat", 32'(tstate), 32'd0);

    // HLT
    ir = 16'h00E0;
    repeat (5) step();
    chk("hlt_state", 32'(tstate), 32'd15);
    chk("hlt_flag", 32'(halted), 32'd1);
    halt_act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mid_en || bus.sid_en || bus.pc_inr || tstate != 4'd15)
        halt_act++;
    end
    chk("hlt_quiet", 32'(halt_act), 32'd0);
    ir = 16'h0000;
    reset = 1'b1;
    #2;
    chk("hlt_rst_state", 32'(tstate), 32'd0);
    chk("hlt_rst_flag", 32'(halted), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("hlt_restart", 32'(tstate), 32'd1);

    // async reset during T3
    step();
    step();
    chk("t3_state", 32'(tstate), 32'd3);
    chk("t3_bus", 32'(bus.control_bus), 32'h01027);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(tstate), 32'd0);
    chk("arst_bus", 32'(bus.control_bus), 32'h01000);
    step();
    reset = 1'b0;
    step();
    chk("arst_restart", 32'(tstate), 32'd1);
    chk("arst_restart_bus", 32'(bus.control_bus), 32'h01007);

    chk("invariants", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
